// File: rtl/mips_data_bus_bridge_if.sv
// Waitrequest-style memory bus between the data bus bridge (master) and the
// shared memory (slave).
interface mips_data_bus_bridge_if;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_waitrequest, avm_readdata
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_waitrequest, avm_readdata
  );
endinterface

// File: rtl/mips_data_bus_bridge.sv
// Bridges the core's single-cycle data port onto a waitrequest bus, freezing the
// core via clk_enable until each access completes, times out, or errors.
module mips_data_bus_bridge #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERROR_READDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_writedata,
  input  logic [3:0]  cpu_byteenable,
  output logic [31:0] cpu_readdata,
  output logic        cpu_clk_enable,
  mips_data_bus_bridge_if.master avm,
  output logic        bus_error
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [31:0]       address_reg;
  logic [31:0]       writedata_reg;
  logic [3:0]        byteenable_reg;
  logic              read_reg;
  logic              write_reg;
  logic [31:0]       readdata_reg;
  logic              bus_error_reg;

  logic              cpu_request;
  logic [3:0]        byteenable_next;
  logic              addr_lsb_unused;

  assign cpu_request     = cpu_read | cpu_write;
  assign byteenable_next = (cpu_byteenable == 4'b0000) ? 4'b1111 : cpu_byteenable;
  assign addr_lsb_unused = ^cpu_address[1:0];

  // DONE is the single cycle in which the core is let through to commit.
  assign cpu_clk_enable = !(cpu_request && (state_reg != DONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      address_reg    <= '0;
      writedata_reg  <= '0;
      byteenable_reg <= '0;
      read_reg       <= 1'b0;
      write_reg      <= 1'b0;
      readdata_reg   <= '0;
      bus_error_reg  <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (cpu_request) begin
            address_reg    <= {cpu_address[31:2], 2'b00};
            writedata_reg  <= cpu_writedata;
            byteenable_reg <= byteenable_next;
            // A conflicting read+write is resolved as a write and flagged.
            read_reg       <= cpu_read & ~cpu_write;
            write_reg      <= cpu_write;
            count_reg      <= '0;
            if (cpu_read && cpu_write) begin
              bus_error_reg <= 1'b1;
            end
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (!avm.avm_waitrequest) begin
            if (read_reg) begin
              readdata_reg <= avm.avm_readdata;
            end
            read_reg  <= 1'b0;
            write_reg <= 1'b0;
            count_reg <= '0;
            state_reg <= DONE;
          end else if (count_reg == CNT_LAST) begin
            if (read_reg) begin
              readdata_reg <= ERROR_READDATA;
            end
            read_reg      <= 1'b0;
            write_reg     <= 1'b0;
            bus_error_reg <= 1'b1;
            count_reg     <= '0;
            state_reg     <= DONE;
          end else begin
            count_reg <= count_reg + CNT_W'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign avm.avm_address    = address_reg;
  assign avm.avm_read       = read_reg;
  assign avm.avm_write      = write_reg;
  assign avm.avm_writedata  = writedata_reg;
  assign avm.avm_byteenable = byteenable_reg;
  assign cpu_readdata       = readdata_reg;
  assign bus_error          = bus_error_reg;

endmodule

// File: tb/tb_mips_data_bus_bridge.sv
// Randomised scoreboard bench: a transaction-level memory model predicts each
// access; a negedge monitor checks bus and core-side behaviour per commit.
module tb_mips_data_bus_bridge;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic [31:0] cpu_readdata;
  logic        cpu_clk_enable;
  logic        bus_error;

  mips_data_bus_bridge_if bus();

  mips_data_bus_bridge #(.TIMEOUT_CYCLES(TO), .ERROR_READDATA(32'hDEADBEEF)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_address    (cpu_address),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_writedata  (cpu_writedata),
    .cpu_byteenable (cpu_byteenable),
    .cpu_readdata   (cpu_readdata),
    .cpu_clk_enable (cpu_clk_enable),
    .avm            (bus),
    .bus_error      (bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        rd;
    bit        wr;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [3:0]  be;
    int        strobes;
    bit [31:0] rdata;
    bit        err;
  } exp_t;

  exp_t exp_q[$];
  int   slave_q[$];
  bit [31:0] ref_mem [bit [29:0]];
  bit [31:0] slv_mem [bit [29:0]];
  bit   ref_err;
  int   checks = 0;
  int   errors = 0;
  int   txn_no = 0;

  function automatic bit [31:0] init_word(bit [29:0] w);
    return {w[13:0], 2'b00, ~w[15:0]} ^ 32'hA5C3_0F96;
  endfunction

  function automatic bit [31:0] ref_rd(bit [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  function automatic bit [31:0] slv_rd(bit [29:0] w);
    return slv_mem.exists(w) ? slv_mem[w] : init_word(w);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- bus slave: waitrequest shaped by slave_q ----------------
  bit active = 0;
  int remaining = 0;
  initial begin
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = 32'h0;
  end
  always @(posedge clk) begin
    #1;
    if (reset || !(bus.avm_read || bus.avm_write)) begin
      active = 0;
      bus.avm_waitrequest = 1'b0;
    end else begin
      if (!active) begin
        active = 1;
        remaining = (slave_q.size() > 0) ? slave_q.pop_front() : 0;
      end else if (remaining > 0) begin
        remaining--;
      end
      bus.avm_waitrequest = (remaining > 0);
      bus.avm_readdata = bus.avm_waitrequest ? $urandom() : slv_rd(bus.avm_address[31:2]);
    end
  end
  always @(negedge clk) begin
    if (!reset && bus.avm_write && !bus.avm_waitrequest) begin
      bit [31:0] w;
      w = slv_rd(bus.avm_address[31:2]);
      for (int i = 0; i < 4; i++)
        if (bus.avm_byteenable[i]) w[8*i +: 8] = bus.avm_writedata[8*i +: 8];
      slv_mem[bus.avm_address[31:2]] = w;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit        prev_strobe = 0;
  int        n_txn = 0, strobe_cyc = 0, stall = 0;
  bit        stable = 1;
  bit        rec_rd, rec_wr;
  bit [31:0] rec_addr, rec_wdata;
  bit [3:0]  rec_be;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_strobe = 0; n_txn = 0; strobe_cyc = 0; stall = 0; stable = 1;
    end else begin
      if (bus.avm_read || bus.avm_write) begin
        if (!prev_strobe) begin
          n_txn++; strobe_cyc = 1; stable = 1;
          rec_rd = bus.avm_read; rec_wr = bus.avm_write; rec_addr = bus.avm_address;
          rec_wdata = bus.avm_writedata; rec_be = bus.avm_byteenable;
        end else begin
          strobe_cyc++;
          if (rec_rd != bus.avm_read || rec_wr != bus.avm_write || rec_addr != bus.avm_address ||
              rec_wdata != bus.avm_writedata || rec_be != bus.avm_byteenable)
            stable = 0;
        end
      end
      prev_strobe = bus.avm_read || bus.avm_write;
      if (cpu_read || cpu_write) begin
        if (!cpu_clk_enable) begin
          stall++;
        end else if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL commit: got unexpected commit, required none queued (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          txn_no++;
          chk("bus_txns", 32'(n_txn), 32'd1);
          chk("kind", {30'd0, rec_rd, rec_wr}, {30'd0, e.rd, e.wr});
          chk("addr", rec_addr, e.addr);
          chk("be", {28'd0, rec_be}, {28'd0, e.be});
          if (e.wr) chk("wdata", rec_wdata, e.wdata);
          chk("strobe_cycles", 32'(strobe_cyc), 32'(e.strobes));
          chk("stable", {31'd0, stable}, 32'd1);
          chk("stall", 32'(stall), 32'(e.strobes + 1));
          if (e.rd) chk("rdata", cpu_readdata, e.rdata);
          chk("bus_error", {31'd0, bus_error}, {31'd0, e.err});
          $display("txn %0d %s addr=%h be=%b strobes=%0d stall=%0d rdata=%h err=%b",
                   txn_no, e.wr ? "WR" : "RD", rec_addr, rec_be, strobe_cyc, stall,
                   cpu_readdata, bus_error);
          n_txn = 0; stall = 0; strobe_cyc = 0;
        end
      end
    end
  end

  // ---------------- core-side driver with reference model ----------------
  task automatic recover();
    reset = 1'b1;
    cpu_read = 1'b0; cpu_write = 1'b0;
    exp_q.delete(); slave_q.delete(); ref_err = 0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic issue(bit rd, bit wr, bit [31:0] addr, bit [31:0] wdata, bit [3:0] be, int waits);
    exp_t e;
    bit [3:0]  ben;
    bit [31:0] w;
    bit        to;
    int        n;
    bit        done;
    ben = (be == 4'b0000) ? 4'b1111 : be;
    to  = (waits >= TO);
    e.wr = wr; e.rd = rd && !wr;
    e.addr = {addr[31:2], 2'b00}; e.wdata = wdata; e.be = ben;
    e.strobes = to ? TO : waits + 1;
    e.rdata = to ? 32'hDEADBEEF : ref_rd(addr[31:2]);
    if (wr && !to) begin
      w = ref_rd(addr[31:2]);
      for (int i = 0; i < 4; i++) if (ben[i]) w[8*i +: 8] = wdata[8*i +: 8];
      ref_mem[addr[31:2]] = w;
    end
    ref_err = ref_err | to | (rd & wr);
    e.err = ref_err;
    exp_q.push_back(e);
    slave_q.push_back(waits);
    cpu_read = rd; cpu_write = wr; cpu_address = addr;
    cpu_writedata = wdata; cpu_byteenable = be;
    n = 0; done = 0;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
      if (cpu_clk_enable) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL commit_timeout: got no clk_enable in %0d cycles, required commit", n);
      recover();
    end else begin
      @(posedge clk); #1;
      cpu_read = 1'b0; cpu_write = 1'b0;
    end
  endtask

  task automatic rand_txn();
    int r, waits, op;
    bit [31:0] a;
    op = $urandom_range(0, 9);
    r  = $urandom_range(0, 15);
    waits = (r < 10) ? (r % 3) : (r - 8);
    a = 32'h0000_2000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
    issue(op <= 4, op == 0 || op >= 5, a, $urandom(), 4'($urandom_range(0, 15)), waits);
    if ($urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; ref_err = 0;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_writedata = '0; cpu_byteenable = '0;
    #1;
    chk("rst_avm_read", {31'd0, bus.avm_read}, 32'd0);
    chk("rst_avm_write", {31'd0, bus.avm_write}, 32'd0);
    chk("rst_avm_address", bus.avm_address, 32'd0);
    chk("rst_avm_be", {28'd0, bus.avm_byteenable}, 32'd0);
    chk("rst_cpu_readdata", cpu_readdata, 32'd0);
    chk("rst_bus_error", {31'd0, bus_error}, 32'd0);
    chk("rst_clk_enable", {31'd0, cpu_clk_enable}, 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    ref_mem[30'h401] = 32'h1234_5678;
    slv_mem[30'h401] = 32'h1234_5678;
    issue(1, 0, 32'h0000_1006, 32'h0, 4'hF, 0);
    issue(0, 1, 32'h0000_1008, 32'hCAFE_F00D, 4'b0011, 5);
    issue(1, 0, 32'h0000_100C, 32'h0, 4'b0000, 10);
    issue(1, 0, 32'h0000_1008, 32'h0, 4'b1111, 1);
    issue(0, 1, 32'h0000_1010, 32'h0BAD_F00D, 4'b1100, 0);
    issue(1, 1, 32'h0000_1014, 32'h5555_AAAA, 4'b1111, 1);
    for (int i = 0; i < 50; i++) rand_txn();

    // Asynchronous reset in the middle of a long-waiting read.
    slave_q.push_back(20);
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 32'h0000_2010; cpu_byteenable = 4'hF;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("pre_reset_strobe", {31'd0, bus.avm_read}, 32'd1);
    reset = 1'b1;
    cpu_read = 1'b0;
    #1;
    chk("async_avm_read", {31'd0, bus.avm_read}, 32'd0);
    chk("async_avm_write", {31'd0, bus.avm_write}, 32'd0);
    chk("async_bus_error", {31'd0, bus_error}, 32'd0);
    chk("async_clk_enable", {31'd0, cpu_clk_enable}, 32'd1);
    exp_q.delete(); slave_q.delete(); ref_err = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    issue(1, 0, 32'h0000_1006, 32'h0, 4'hF, 0);
    for (int i = 0; i < 12; i++) rand_txn();

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t, required finish", $time);
    $fatal(1, "watchdog");
  end
endmodule
